// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator for a word-only, big-endian memory port.
// Adds byte/halfword loads with extension, read-modify-write sub-word stores and misalignment flagging.
module mem_lsu #(
    parameter int XLEN            = 32,
    parameter int PART_ADDR_WIDTH = 12
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_store_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_data_o,
    output logic            resp_err_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic [XLEN-1:0] ram_data_o,
    output logic            mem_we_o,
    input  logic [XLEN-1:0] ram_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   wr_data_q;
    logic              err_q;
    logic              accept_s;
    logic              err_s;

    // The memory only decodes the low address bits; the full address is forwarded untouched.
    if (PART_ADDR_WIDTH > XLEN) begin : g_part_addr_unused
    end

    function automatic logic access_err(input logic store, input logic [2:0] f3, input logic [1:0] off);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = off[0];
            3'b010:  e = (off != 2'b00);
            3'b100:  e = store;
            3'b101:  e = store | off[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [XLEN-1:0] merge_word(input logic [XLEN-1:0] old, input logic [XLEN-1:0] wd,
                                                   input logic [2:0] f3, input logic [1:0] off);
        logic [XLEN-1:0] m;
        m = old;
        case (f3[1:0])
            2'b00: begin
                case (off)
                    2'b00:   m[31:24] = wd[7:0];
                    2'b01:   m[23:16] = wd[7:0];
                    2'b10:   m[15:8]  = wd[7:0];
                    default: m[7:0]   = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    m[15:0] = wd[15:0];
                end else begin
                    m[31:16] = wd[15:0];
                end
            end
            2'b10:   m = wd;
            default: m = old;
        endcase
        return m;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] w, input logic [2:0] f3,
                                                     input logic [1:0] off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (off)
            2'b00:   b = w[31:24];
            2'b01:   b = w[23:16];
            2'b10:   b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    assign req_ready_o = (state_q == ST_IDLE) && rst_n_i;
    assign accept_s    = req_valid_i && req_ready_o;
    assign err_s       = access_err(req_store_i, req_funct3_i, req_addr_i[1:0]);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (err_s || !req_store_i) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request capture; the merged store word is formed at accept so ram_data_o is a plain register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            store_q   <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= {XLEN{1'b0}};
            old_q     <= {XLEN{1'b0}};
            wr_data_q <= {XLEN{1'b0}};
            err_q     <= 1'b0;
        end else if (accept_s) begin
            store_q  <= req_store_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            old_q    <= ram_data_i;
            err_q    <= err_s;
            if (req_store_i && !err_s) begin
                wr_data_q <= merge_word(ram_data_i, req_wdata_i, req_funct3_i, req_addr_i[1:0]);
            end else begin
                wr_data_q <= wr_data_q;
            end
        end else begin
            store_q   <= store_q;
            funct3_q  <= funct3_q;
            addr_q    <= addr_q;
            old_q     <= old_q;
            wr_data_q <= wr_data_q;
            err_q     <= err_q;
        end
    end

    assign ram_data_o = wr_data_q;

    // Output decode; write enable and response are gated by reset so an interrupted access has no effect.
    always_comb begin
        ram_addr_o   = req_addr_i;
        mem_we_o     = 1'b0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        resp_data_o  = {XLEN{1'b0}};
        case (state_q)
            ST_IDLE: begin
                ram_addr_o = req_addr_i;
            end
            ST_WRITE: begin
                ram_addr_o = addr_q;
                mem_we_o   = rst_n_i;
            end
            ST_DONE: begin
                ram_addr_o   = addr_q;
                resp_valid_o = rst_n_i;
                resp_err_o   = err_q && rst_n_i;
                if (store_q || err_q || !rst_n_i) begin
                    resp_data_o = {XLEN{1'b0}};
                end else begin
                    resp_data_o = load_extract(old_q, funct3_q, addr_q[1:0]);
                end
            end
            default: begin
                ram_addr_o = req_addr_i;
            end
        endcase
    end

endmodule
